// File: rtl/pipelined_alu_if.sv
// pipelined_alu_if: request/response bundle between the EX-stage operand muxes and pipelined_alu.
// The master drives the request side; the slave (the ALU) returns ready, result, flag and busy.
interface pipelined_alu_if #(
  parameter int XLEN = 32
);
  logic            Valid_i;
  logic            Ready_o;
  logic [XLEN-1:0] OperandA_i;
  logic [XLEN-1:0] OperandB_i;
  logic [3:0]      ALUCtrl_i;
  logic [2:0]      Flagsel_i;
  logic            Valid_o;
  logic [XLEN-1:0] Result_o;
  logic            Flag_o;
  logic            Busy_o;

  modport master (
    output Valid_i, OperandA_i, OperandB_i, ALUCtrl_i, Flagsel_i,
    input  Ready_o, Valid_o, Result_o, Flag_o, Busy_o
  );

  modport slave (
    input  Valid_i, OperandA_i, OperandB_i, ALUCtrl_i, Flagsel_i,
    output Ready_o, Valid_o, Result_o, Flag_o, Busy_o
  );
endinterface

// File: rtl/pipelined_alu.sv
// pipelined_alu: registered RV32I ALU with valid/ready input handshake, SLT/SLTU and branch flag.
// Define ALU_MULDIV_EN to build the iterative radix-2 unsigned MUL/MULHU/DIVU/REMU engine.
module pipelined_alu #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic           Clk_i,
  input  logic           Rst_i,
  pipelined_alu_if.slave alu_if
);

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_SLL   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_SRL   = 4'b0100;
  localparam logic [3:0] OP_SRA   = 4'b0101;
  localparam logic [3:0] OP_OR    = 4'b0110;
  localparam logic [3:0] OP_AND   = 4'b0111;
  localparam logic [3:0] OP_LUI   = 4'b1000;
  localparam logic [3:0] OP_SLT   = 4'b1001;
  localparam logic [3:0] OP_SLTU  = 4'b1010;
  localparam logic [3:0] OP_MUL   = 4'b1011;
  localparam logic [3:0] OP_MULHU = 4'b1100;
  localparam logic [3:0] OP_DIVU  = 4'b1101;
  localparam logic [3:0] OP_REMU  = 4'b1110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
`ifdef ALU_MULDIV_EN
    BUSY = 2'd1,
`endif
    DONE = 2'd2
  } state_e;

  // Single-cycle datapath; multi-cycle and reserved codes fall through to zero.
  function automatic logic [XLEN-1:0] alu_result(
    input logic [3:0]      ctrl,
    input logic [XLEN-1:0] a,
    input logic [XLEN-1:0] b
  );
    logic [SHAMT_W-1:0] shamt;
    logic [XLEN-1:0]    res;
    shamt = b[SHAMT_W-1:0];
    case (ctrl)
      OP_ADD:  res = a + b;
      OP_SUB:  res = a - b;
      OP_SLL:  res = a << shamt;
      OP_XOR:  res = a ^ b;
      OP_SRL:  res = a >> shamt;
      OP_SRA:  res = $signed(a) >>> shamt;
      OP_OR:   res = a | b;
      OP_AND:  res = a & b;
      OP_LUI:  res = b << 5'd12;
      OP_SLT:  res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: res = {{(XLEN-1){1'b0}}, (a < b)};
      default: res = {XLEN{1'b0}};
    endcase
    return res;
  endfunction

  function automatic logic branch_flag(
    input logic [2:0]      fsel,
    input logic [XLEN-1:0] a,
    input logic [XLEN-1:0] b
  );
    logic f;
    case (fsel)
      3'b000:  f = (a == b);
      3'b001:  f = (a != b);
      3'b100:  f = ($signed(a) < $signed(b));
      3'b101:  f = ($signed(a) >= $signed(b));
      3'b110:  f = (a < b);
      3'b111:  f = (a >= b);
      default: f = 1'b0;
    endcase
    return f;
  endfunction

  state_e          state_q, state_d;
  logic            valid_q, valid_d;
  logic            ready_q, ready_d;
  logic            busy_q, busy_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            flag_q, flag_d;
  logic            accept_s;

`ifdef ALU_MULDIV_EN
  // hi/lo hold {product} for multiply and {remainder, quotient} for divide.
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]    hi_q, hi_d;
  logic [XLEN-1:0]    lo_q, lo_d;
  logic [XLEN-1:0]    opb_q, opb_d;
  logic [3:0]         op_q, op_d;
  logic               flag_pend_q, flag_pend_d;
  logic               is_multi_s;
  logic               is_mul_s;
  logic [XLEN:0]      mul_sum_s;
  logic [XLEN:0]      div_shift_s;
  logic [XLEN:0]      div_diff_s;

  assign is_multi_s = (alu_if.ALUCtrl_i == OP_MUL)  || (alu_if.ALUCtrl_i == OP_MULHU) ||
                      (alu_if.ALUCtrl_i == OP_DIVU) || (alu_if.ALUCtrl_i == OP_REMU);
  assign is_mul_s   = (op_q == OP_MUL) || (op_q == OP_MULHU);
  assign accept_s   = alu_if.Valid_i && (state_q != BUSY);
`else
  assign accept_s   = alu_if.Valid_i;
`endif

  // Next-state, datapath step and output computation.
  always_comb begin
    state_d  = state_q;
    valid_d  = 1'b0;
    result_d = result_q;
    flag_d   = flag_q;
`ifdef ALU_MULDIV_EN
    cnt_d       = cnt_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    opb_d       = opb_q;
    op_d        = op_q;
    flag_pend_d = flag_pend_q;
    mul_sum_s   = {(XLEN+1){1'b0}};
    div_shift_s = {(XLEN+1){1'b0}};
    div_diff_s  = {(XLEN+1){1'b0}};
`endif
    case (state_q)
      IDLE, DONE: begin
        if (accept_s) begin
`ifdef ALU_MULDIV_EN
          if (is_multi_s) begin
            state_d     = BUSY;
            cnt_d       = SHAMT_W'(XLEN - 1);
            op_d        = alu_if.ALUCtrl_i;
            opb_d       = (alu_if.ALUCtrl_i == OP_MUL || alu_if.ALUCtrl_i == OP_MULHU) ?
                          alu_if.OperandA_i : alu_if.OperandB_i;
            lo_d        = (alu_if.ALUCtrl_i == OP_MUL || alu_if.ALUCtrl_i == OP_MULHU) ?
                          alu_if.OperandB_i : alu_if.OperandA_i;
            hi_d        = {XLEN{1'b0}};
            flag_pend_d = branch_flag(alu_if.Flagsel_i, alu_if.OperandA_i, alu_if.OperandB_i);
          end else begin
            state_d  = DONE;
            valid_d  = 1'b1;
            result_d = alu_result(alu_if.ALUCtrl_i, alu_if.OperandA_i, alu_if.OperandB_i);
            flag_d   = branch_flag(alu_if.Flagsel_i, alu_if.OperandA_i, alu_if.OperandB_i);
          end
`else
          state_d  = DONE;
          valid_d  = 1'b1;
          result_d = alu_result(alu_if.ALUCtrl_i, alu_if.OperandA_i, alu_if.OperandB_i);
          flag_d   = branch_flag(alu_if.Flagsel_i, alu_if.OperandA_i, alu_if.OperandB_i);
`endif
        end else begin
          state_d = IDLE;
        end
      end
`ifdef ALU_MULDIV_EN
      BUSY: begin
        if (is_mul_s) begin
          mul_sum_s    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : {(XLEN+1){1'b0}});
          {hi_d, lo_d} = {mul_sum_s, lo_q[XLEN-1:1]};
        end else begin
          // Restoring division; a zero divisor naturally yields all-ones / dividend.
          div_shift_s = {hi_q, lo_q[XLEN-1]};
          div_diff_s  = div_shift_s - {1'b0, opb_q};
          if (div_shift_s >= {1'b0, opb_q}) begin
            hi_d = div_diff_s[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], 1'b1};
          end else begin
            hi_d = div_shift_s[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], 1'b0};
          end
        end
        if (cnt_q == {SHAMT_W{1'b0}}) begin
          state_d = DONE;
          valid_d = 1'b1;
          flag_d  = flag_pend_q;
          case (op_q)
            OP_MUL:   result_d = lo_d;
            OP_MULHU: result_d = hi_d;
            OP_DIVU:  result_d = lo_d;
            OP_REMU:  result_d = hi_d;
            default:  result_d = {XLEN{1'b0}};
          endcase
        end else begin
          cnt_d = cnt_q - SHAMT_W'(1);
        end
      end
`endif
      default: state_d = IDLE;
    endcase
`ifdef ALU_MULDIV_EN
    ready_d = (state_d != BUSY);
    busy_d  = (state_d == BUSY);
`else
    ready_d = 1'b1;
    busy_d  = 1'b0;
`endif
  end

  // State and output registers with synchronous reset that discards any in-flight op.
  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      state_q  <= IDLE;
      valid_q  <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      result_q <= {XLEN{1'b0}};
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      result_q <= result_d;
      flag_q   <= flag_d;
    end
  end

`ifdef ALU_MULDIV_EN
  // Multiply/divide engine registers.
  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      cnt_q       <= {SHAMT_W{1'b0}};
      hi_q        <= {XLEN{1'b0}};
      lo_q        <= {XLEN{1'b0}};
      opb_q       <= {XLEN{1'b0}};
      op_q        <= 4'b0000;
      flag_pend_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      opb_q       <= opb_d;
      op_q        <= op_d;
      flag_pend_q <= flag_pend_d;
    end
  end
`endif

  assign alu_if.Valid_o  = valid_q;
  assign alu_if.Ready_o  = ready_q;
  assign alu_if.Busy_o   = busy_q;
  assign alu_if.Result_o = result_q;
  assign alu_if.Flag_o   = flag_q;

endmodule

// File: tb/tb_pipelined_alu.sv
// tb_pipelined_alu: table-driven directed test of pipelined_alu (XLEN=32) plus hand-written
// sequences for back-to-back issue, reset precedence and, with ALU_MULDIV_EN, multi-cycle ops.
module tb_pipelined_alu;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  pipelined_alu_if #(.XLEN(32)) bus();

  pipelined_alu #(.XLEN(32)) dut (
    .Clk_i  (clk),
    .Rst_i  (rst),
    .alu_if (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  ctrl;
    logic [2:0]  fsel;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    logic        exp_flag;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] c, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] b);
    bus.Valid_i    = v;
    bus.ALUCtrl_i  = c;
    bus.Flagsel_i  = f;
    bus.OperandA_i = a;
    bus.OperandB_i = b;
  endtask

  task automatic add_vec(input logic [3:0] c, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] r, input logic fl);
    vec_t v;
    v.ctrl = c; v.fsel = f; v.a = a; v.b = b; v.exp_res = r; v.exp_flag = fl;
    vecs.push_back(v);
  endtask

`ifdef ALU_MULDIV_EN
  // Issue a multi-cycle op, poke Valid_i mid-flight, and check latency/ready/result/flag.
  task automatic run_multi(input string name, input logic [3:0] c, input logic [2:0] f,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_res, input logic exp_flag);
    int lat;
    int ready_low;
    int busy_hi;
    drive(1'b1, c, f, a, b);
    step();
    drive(1'b0, 4'b0000, 3'b000, 32'h0, 32'h0);
    lat = 1;
    ready_low = 0;
    busy_hi = 0;
    while (!bus.Valid_o && lat < 100) begin
      if (!bus.Ready_o) ready_low++;
      if (bus.Busy_o) busy_hi++;
      if (lat == 5) drive(1'b1, 4'b0000, 3'b000, 32'h1111_1111, 32'h2222_2222);
      else drive(1'b0, 4'b0000, 3'b000, 32'h0, 32'h0);
      step();
      lat++;
    end
    chk({name, "_latency"}, 64'(lat), 64'd33);
    chk({name, "_ready_low"}, 64'(ready_low), 64'd32);
    chk({name, "_busy_hi"}, 64'(busy_hi), 64'd32);
    chk({name, "_result"}, 64'(bus.Result_o), 64'(exp_res));
    chk({name, "_flag"}, 64'(bus.Flag_o), 64'(exp_flag));
    step();
    chk({name, "_no_extra_valid"}, 64'(bus.Valid_o), 64'd0);
    chk({name, "_hold"}, 64'(bus.Result_o), 64'(exp_res));
  endtask
`endif

  initial begin
    int pulses;
    drive(1'b0, 4'b0000, 3'b000, 32'h0, 32'h0);

    add_vec(4'b0000, 3'b100, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0);
    add_vec(4'b0001, 3'b000, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1);
    add_vec(4'b0101, 3'b001, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 1'b1);
    add_vec(4'b1001, 3'b100, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b1);
    add_vec(4'b1010, 3'b110, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0);
    add_vec(4'b1000, 3'b010, 32'h0000_0000, 32'h0001_2345, 32'h1234_5000, 1'b0);
    add_vec(4'b0010, 3'b111, 32'h0000_0001, 32'h0000_0021, 32'h0000_0002, 1'b0);
    add_vec(4'b0100, 3'b101, 32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 1'b0);
    add_vec(4'b0011, 3'b011, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0);
    add_vec(4'b0110, 3'b101, 32'h0F0F_0000, 32'h0000_00F0, 32'h0F0F_00F0, 1'b1);
    add_vec(4'b0111, 3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0);
    add_vec(4'b1111, 3'b110, 32'h0000_0123, 32'h0000_0456, 32'h0000_0000, 1'b1);
    add_vec(4'b0001, 3'b111, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0);
    add_vec(4'b0101, 3'b100, 32'h7FFF_FFFF, 32'h0000_001F, 32'h0000_0000, 1'b0);
    add_vec(4'b0000, 3'b110, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0);
`ifndef ALU_MULDIV_EN
    add_vec(4'b1011, 3'b001, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0000, 1'b1);
    add_vec(4'b1100, 3'b110, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0000, 1'b0);
    add_vec(4'b1101, 3'b111, 32'h0000_0064, 32'h0000_0007, 32'h0000_0000, 1'b1);
    add_vec(4'b1110, 3'b000, 32'h0000_0009, 32'h0000_0000, 32'h0000_0000, 1'b0);
`endif

    // Reset state
    step();
    step();
    rst = 1'b0;
    chk("reset_valid", 64'(bus.Valid_o), 64'd0);
    chk("reset_result", 64'(bus.Result_o), 64'd0);
    chk("reset_flag", 64'(bus.Flag_o), 64'd0);
    chk("reset_busy", 64'(bus.Busy_o), 64'd0);
    chk("reset_ready", 64'(bus.Ready_o), 64'd1);

    // Table of single-cycle vectors, one accept per vector
    foreach (vecs[i]) begin
      drive(1'b1, vecs[i].ctrl, vecs[i].fsel, vecs[i].a, vecs[i].b);
      step();
      drive(1'b0, 4'b0000, 3'b000, 32'h0, 32'h0);
      chk($sformatf("vec%0d_valid", i), 64'(bus.Valid_o), 64'd1);
      chk($sformatf("vec%0d_result", i), 64'(bus.Result_o), 64'(vecs[i].exp_res));
      chk($sformatf("vec%0d_flag", i), 64'(bus.Flag_o), 64'(vecs[i].exp_flag));
      chk($sformatf("vec%0d_ready", i), 64'(bus.Ready_o), 64'd1);
      chk($sformatf("vec%0d_busy", i), 64'(bus.Busy_o), 64'd0);
      step();
      chk($sformatf("vec%0d_pulse_end", i), 64'(bus.Valid_o), 64'd0);
      chk($sformatf("vec%0d_hold", i), 64'(bus.Result_o), 64'(vecs[i].exp_res));
    end

    // Back-to-back ADD, XOR, AND with Valid_i held high
    drive(1'b1, 4'b0000, 3'b000, 32'h0000_0003, 32'h0000_0004);
    step();
    chk("b2b_add_valid", 64'(bus.Valid_o), 64'd1);
    chk("b2b_add_result", 64'(bus.Result_o), 64'h7);
    chk("b2b_add_ready", 64'(bus.Ready_o), 64'd1);
    drive(1'b1, 4'b0011, 3'b001, 32'h0000_000F, 32'h0000_0005);
    step();
    chk("b2b_xor_valid", 64'(bus.Valid_o), 64'd1);
    chk("b2b_xor_result", 64'(bus.Result_o), 64'hA);
    chk("b2b_xor_flag", 64'(bus.Flag_o), 64'd1);
    chk("b2b_xor_ready", 64'(bus.Ready_o), 64'd1);
    drive(1'b1, 4'b0111, 3'b000, 32'h0000_00FF, 32'h0000_0F0F);
    step();
    drive(1'b0, 4'b0000, 3'b000, 32'h0, 32'h0);
    chk("b2b_and_valid", 64'(bus.Valid_o), 64'd1);
    chk("b2b_and_result", 64'(bus.Result_o), 64'hF);
    chk("b2b_and_flag", 64'(bus.Flag_o), 64'd0);
    step();
    chk("b2b_idle_valid", 64'(bus.Valid_o), 64'd0);
    chk("b2b_idle_hold", 64'(bus.Result_o), 64'hF);

    // Reset takes precedence over an accept in the same cycle
    drive(1'b1, 4'b0000, 3'b000, 32'h0000_0010, 32'h0000_0020);
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive(1'b0, 4'b0000, 3'b000, 32'h0, 32'h0);
    chk("rst_accept_valid", 64'(bus.Valid_o), 64'd0);
    chk("rst_accept_result", 64'(bus.Result_o), 64'd0);
    step();
    chk("rst_accept_later_valid", 64'(bus.Valid_o), 64'd0);

`ifdef ALU_MULDIV_EN
    run_multi("mul",   4'b1011, 3'b000, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE, 1'b0);
    run_multi("mulhu", 4'b1100, 3'b110, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 1'b0);
    run_multi("divu",  4'b1101, 3'b111, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E, 1'b1);
    run_multi("remu",  4'b1110, 3'b001, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 1'b1);
    run_multi("divu0", 4'b1101, 3'b101, 32'h0000_0009, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1);
    run_multi("remu0", 4'b1110, 3'b000, 32'h0000_0009, 32'h0000_0000, 32'h0000_0009, 1'b0);

    // Reset at cycle 10 of a DIVU aborts it without a result
    drive(1'b1, 4'b1101, 3'b000, 32'h0000_0064, 32'h0000_0007);
    step();
    drive(1'b0, 4'b0000, 3'b000, 32'h0, 32'h0);
    chk("abort_busy_before", 64'(bus.Busy_o), 64'd1);
    for (int k = 0; k < 9; k++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_ready", 64'(bus.Ready_o), 64'd1);
    chk("abort_busy", 64'(bus.Busy_o), 64'd0);
    chk("abort_result", 64'(bus.Result_o), 64'd0);
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      if (bus.Valid_o) pulses++;
      step();
    end
    chk("abort_no_valid", 64'(pulses), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipelined_alu.md
Name: pipelined_alu

Overview:
- Parametrised, registered successor to the single-cycle RV32I ALU.
- Adds a valid/ready input handshake, a registered result and branch flag, and SLT/SLTU.
- With the optional feature enabled, adds an iterative radix-2 multiply/divide engine for the M-extension unsigned subset.
- Sits in the EX stage between operand muxes and EX/MEM register; stalls the pipeline via Ready_o while a multi-cycle op runs.

Parameters:
- XLEN, 32: datapath width; any power of two, 8 to 64.
- SHAMT_W, $clog2(XLEN): number of shift-amount bits taken from OperandB_i.

Ports:
- Clk_i  input  1  clock; all state updates on the rising edge.
- Rst_i  input  1  synchronous, active-high reset.
- Valid_i  input  1  operation request.
- Ready_o  output  1  unit can accept a request this cycle.
- OperandA_i  input  XLEN  source A.
- OperandB_i  input  XLEN  source B or immediate.
- ALUCtrl_i  input  4  operation select.
- Flagsel_i  input  3  branch condition select (funct3).
- Valid_o  output  1  one-cycle pulse; Result_o and Flag_o are valid in that cycle.
- Result_o  output  XLEN  registered result.
- Flag_o  output  1  registered branch flag.
- Busy_o  output  1  multi-cycle operation in progress.

Behaviour:
- Reset: the following apply on the next edge, including when reset is asserted mid-operation. Any in-flight op is discarded; it never produces Valid_o.
  - state=IDLE.
  - Valid_o=0, Result_o=0, Flag_o=0, Busy_o=0.
  - Ready_o=1.
- Handshake:
  - A request is accepted on an edge where Valid_i=1 and Ready_o=1.
  - Ready_o is 0 only in state BUSY. Valid_i while Ready_o=0 is ignored; it is neither queued nor remembered.
  - There is no output back-pressure. Valid_o is high for exactly one cycle per accepted op. Result_o and Flag_o hold their value until the next Valid_o.
- ALUCtrl_i encoding. All arithmetic is modulo 2^XLEN. Shifts use OperandB_i[SHAMT_W-1:0] only.
  - 0000 ADD; 0001 SUB.
  - 0010 SLL; 0011 XOR.
  - 0100 SRL; 0101 SRA (arithmetic, sign-filling).
  - 0110 OR; 0111 AND.
  - 1000 LUI: OperandB_i<<12, truncated to XLEN.
  - 1001 SLT (signed); 1010 SLTU. Result is zero-extended 0 or 1.
  - 1011 MUL (low XLEN bits); 1100 MULHU (high XLEN bits, unsigned).
  - 1101 DIVU; 1110 REMU.
  - 1111 is reserved: single-cycle, result 0.
- Flag:
  - Computed from the accepted operands for every op, regardless of ALUCtrl_i.
  - Flagsel_i: 000 EQ, 001 NE, 100 LT (signed), 101 GE (signed), 110 LTU, 111 GEU.
  - Flagsel_i 010 or 011 gives Flag 0.
  - Flag is registered together with Result and appears with the same Valid_o.
- FSM states: IDLE, BUSY, DONE.
  - IDLE or DONE, accept of a single-cycle op: go to DONE. Valid_o=1 the next cycle, so latency is 1.
  - IDLE or DONE, accept of a multi-cycle op (1011–1110): go to BUSY, iteration counter loaded with XLEN-1, Busy_o=1.
  - BUSY: one shift-add or shift-subtract step per cycle. When counter=0, go to DONE. Valid_o is asserted XLEN+1 cycles after accept (33 for XLEN=32).
  - DONE, no accept: go to IDLE; Valid_o returns to 0.
  - Back-to-back single-cycle ops give one result per cycle.
- Divide by zero: no exception and normal latency.
  - DIVU result = all ones.
  - REMU result = OperandA.
- Operands and control are captured at accept. Input changes during BUSY have no effect.

Optional Feature:
- Macro: ALU_MULDIV_EN.
- Defined: multiply/divide engine, BUSY state and iteration counter are present; codes 1011–1110 behave as above.
- Undefined: engine, counter and BUSY state are not built.
  - Codes 1011–1110 are single-cycle with result 0.
  - Ready_o is constant 1 after reset; Busy_o is constant 0.
  - Flag behaviour is unchanged.

Test Plan:
- ADD, A=0x7FFFFFFF, B=1, Flagsel=100 -> next cycle Valid_o=1, Result=0x80000000, Flag=0. SUB, A=5, B=5, Flagsel=000 -> Result=0, Flag=1.
- SRA, A=0x80000000, B=0x00000024 (shamt 4) -> 0xF8000000. SLT, A=0xFFFFFFFF, B=1 -> 1. SLTU with the same operands -> 0. LUI, B=0x12345 -> 0x12345000.
- Back-to-back ADD, XOR, AND on consecutive cycles with Valid_i held high -> three consecutive Valid_o pulses with the correct results; Ready_o stays 1.
- With ALU_MULDIV_EN defined:
  - MUL, A=0xFFFFFFFF, B=2 -> Result=0xFFFFFFFE. MULHU, same operands -> 1.
  - Both give Valid_o exactly 33 cycles after accept, Ready_o=0 for 32 cycles, and a Valid_i in that window is ignored.
- DIVU, A=100, B=7 -> 14; REMU -> 2. DIVU, A=9, B=0 -> 0xFFFFFFFF; REMU -> 9.
- Assert Rst_i at cycle 10 of a DIVU -> next cycle Ready_o=1, Busy_o=0, Result_o=0; no Valid_o ever appears for the aborted op.
